// File: rtl/lms_weight_update_if.sv
// rtl/lms_weight_update_if.sv - weight RAM and sample-history RAM port bundle
interface lms_weight_update_if #(
  parameter int ADDR_W  = 9,
  parameter int W_WIDTH = 59,
  parameter int X_WIDTH = 16
);
  logic        [ADDR_W-1:0]  x_rd_addr;
  logic signed [X_WIDTH-1:0] x_rd_data;
  logic        [ADDR_W-1:0]  w_rd_addr;
  logic signed [W_WIDTH-1:0] w_rd_data;
  logic        [ADDR_W-1:0]  w_wr_addr;
  logic signed [W_WIDTH-1:0] w_wr_data;
  logic                      w_wr_en;

  modport master (
    output x_rd_addr, input x_rd_data,
    output w_rd_addr, input w_rd_data,
    output w_wr_addr, output w_wr_data, output w_wr_en
  );

  modport slave (
    input x_rd_addr, output x_rd_data,
    input w_rd_addr, output w_rd_data,
    input w_wr_addr, input w_wr_data, input w_wr_en
  );
endinterface

// File: rtl/lms_weight_update.sv
// rtl/lms_weight_update.sv - LMS coefficient update engine with weight clear sweep
module lms_weight_update #(
  parameter int TAPS    = 512,
  parameter int ADDR_W  = 9,
  parameter int W_WIDTH = 59,
  parameter int X_WIDTH = 16,
  parameter int E_WIDTH = 16,
  parameter int SHIFT   = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      clear,
  input  logic signed [E_WIDTH-1:0] mu_e,
  lms_weight_update_if.master       ram,
  output logic                      busy,
  output logic                      done
);
  localparam int P_WIDTH = E_WIDTH + X_WIDTH;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, UPDATE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0]         rd_addr, s1_addr, s2_addr, wr_addr;
  logic                      rd_act, s1_vld, s2_vld, wr_en;
  logic signed [E_WIDTH-1:0] mu_lat;
  logic signed [P_WIDTH-1:0] prod, prod_sh;
  logic signed [W_WIDTH-1:0] w_hold, wr_data, sat;
  logic signed [W_WIDTH:0]   sum;
  logic                      last_wr;

  // Both sweeps end on the cycle that carries the final tap's write.
  assign last_wr = wr_en && (wr_addr == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clear)      state_nxt = CLEAR;
        else if (start) state_nxt = UPDATE;
      end
      CLEAR, UPDATE: begin
        if (last_wr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One guard bit above the weight catches overflow of the addition.
  always_comb begin
    prod_sh = prod >>> SHIFT;
    sum = {w_hold[W_WIDTH-1], w_hold}
        + {{(W_WIDTH + 1 - P_WIDTH){prod_sh[P_WIDTH-1]}}, prod_sh};
    sat = sum[W_WIDTH-1:0];
    if (sum[W_WIDTH] != sum[W_WIDTH-1])
      sat = {sum[W_WIDTH], {(W_WIDTH-1){~sum[W_WIDTH]}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr <= '0;
      rd_act  <= 1'b0;
      s1_addr <= '0;
      s1_vld  <= 1'b0;
      s2_addr <= '0;
      s2_vld  <= 1'b0;
      mu_lat  <= '0;
      prod    <= '0;
      w_hold  <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_en   <= 1'b0;
      done    <= 1'b0;
    end else begin
      done    <= (state != IDLE) && (state_nxt == IDLE);
      s1_vld  <= rd_act;
      s1_addr <= rd_addr;
      s2_vld  <= s1_vld;
      if (s1_vld) begin
        prod    <= P_WIDTH'(mu_lat) * P_WIDTH'(ram.x_rd_data);
        w_hold  <= ram.w_rd_data;
        s2_addr <= s1_addr;
      end
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            wr_addr <= '0;
            wr_data <= '0;
            wr_en   <= 1'b1;
          end else if (start) begin
            mu_lat  <= mu_e;
            rd_addr <= '0;
            rd_act  <= 1'b1;
          end
        end
        CLEAR: begin
          if (!last_wr) begin
            wr_addr <= wr_addr + ADDR_W'(1);
            wr_en   <= 1'b1;
          end
        end
        UPDATE: begin
          if (rd_act) begin
            if (rd_addr == LAST) rd_act <= 1'b0;
            else                 rd_addr <= rd_addr + ADDR_W'(1);
          end
          if (s2_vld) begin
            wr_addr <= s2_addr;
            wr_data <= sat;
            wr_en   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ram.x_rd_addr = rd_addr;
  assign ram.w_rd_addr = rd_addr;
  assign ram.w_wr_addr = wr_addr;
  assign ram.w_wr_data = wr_data;
  assign ram.w_wr_en   = wr_en;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_lms_weight_update.sv
// tb/tb_lms_weight_update.sv - randomized self-checking bench for lms_weight_update
module tb_lms_weight_update;
  localparam int TAPS = 512, ADDR_W = 9, W_WIDTH = 59, X_WIDTH = 16, E_WIDTH = 16, SHIFT = 15;
  localparam longint WMAX = (longint'(1) <<< (W_WIDTH - 1)) - 1;
  localparam longint WMIN = -(longint'(1) <<< (W_WIDTH - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic clear = 1'b0;
  logic signed [E_WIDTH-1:0] mu_e = '0;
  logic busy, done;

  lms_weight_update_if #(.ADDR_W(ADDR_W), .W_WIDTH(W_WIDTH), .X_WIDTH(X_WIDTH)) ram ();

  lms_weight_update #(
    .TAPS(TAPS), .ADDR_W(ADDR_W), .W_WIDTH(W_WIDTH),
    .X_WIDTH(X_WIDTH), .E_WIDTH(E_WIDTH), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .mu_e(mu_e),
    .ram(ram), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic signed [W_WIDTH-1:0] wmem [TAPS];
  logic signed [W_WIDTH-1:0] load_w [TAPS];
  logic signed [W_WIDTH-1:0] old_w [TAPS];
  logic signed [W_WIDTH-1:0] model [TAPS];
  logic signed [X_WIDTH-1:0] xmem [TAPS];
  logic load_req = 1'b0;

  // RAM models: one-cycle read latency, write on the clock edge.
  always @(posedge clk) begin
    ram.w_rd_data <= wmem[ram.w_rd_addr];
    ram.x_rd_data <= xmem[ram.x_rd_addr];
    if (load_req) begin
      for (int k = 0; k < TAPS; k++) wmem[k] <= load_w[k];
    end else if (ram.w_wr_en) begin
      wmem[ram.w_wr_addr] <= ram.w_wr_data;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int addr;
    logic signed [W_WIDTH-1:0] data;
    int cyc;
  } wr_t;
  wr_t expq[$];
  bit armed = 1'b0;
  int exp_start = 0;
  int exp_done = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Weight update from the arithmetic definition: floor division, then clamp.
  function automatic longint upd(input longint w, input longint x, input longint mu);
    longint prod, div, q, s;
    div = longint'(1) << SHIFT;
    prod = mu * x;
    q = prod / div;
    if (prod < 0 && (prod % div) != 0) q = q - 1;
    s = w + q;
    if (s > WMAX) s = WMAX;
    if (s < WMIN) s = WMIN;
    return s;
  endfunction

  always @(negedge clk) begin : cmp
    wr_t e;
    bit bexp;
    if (!rst) begin
      if (ram.w_wr_en) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %0d data %0d expected no write (cycle %0d)",
                   ram.w_wr_addr, ram.w_wr_data, cyc);
        end else begin
          e = expq.pop_front();
          chk("wr_addr", ram.w_wr_addr, e.addr);
          chk("wr_data", ram.w_wr_data, e.data);
          chk("wr_cycle", cyc, e.cyc);
        end
      end
      bexp = armed && (cyc >= exp_start) && (cyc < exp_done);
      chk("busy", busy, bexp);
      if (done) begin
        if (!armed) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          chk("done_cycle", cyc, exp_done);
          armed = 1'b0;
        end
      end
    end
  end

  function automatic logic signed [W_WIDTH-1:0] rnd_w();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0:       return W_WIDTH'(WMAX - longint'($urandom_range(0, 1000)));
      1:       return W_WIDTH'(WMIN + longint'($urandom_range(0, 1000)));
      default: return r[W_WIDTH-1:0];
    endcase
  endfunction

  function automatic logic signed [X_WIDTH-1:0] rnd_x();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 7))
      0:       return 16'sh7fff;
      1:       return 16'sh8000;
      default: return r[X_WIDTH-1:0];
    endcase
  endfunction

  task automatic do_load();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic set_all(input longint w, input logic signed [X_WIDTH-1:0] x);
    for (int k = 0; k < TAPS; k++) begin
      load_w[k] = W_WIDTH'(w);
      xmem[k] = x;
    end
    do_load();
  endtask

  task automatic rand_fill();
    for (int k = 0; k < TAPS; k++) begin
      load_w[k] = rnd_w();
      xmem[k] = rnd_x();
    end
    do_load();
  endtask

  task automatic launch(input bit is_clear, input logic signed [E_WIDTH-1:0] mu, output int c0);
    wr_t e;
    longint t;
    @(negedge clk);
    c0 = cyc + 1;
    for (int k = 0; k < TAPS; k++) begin
      old_w[k] = wmem[k];
      t = is_clear ? 0 : upd(longint'(wmem[k]), longint'(xmem[k]), longint'(mu));
      model[k] = W_WIDTH'(t);
      e.addr = k;
      e.data = model[k];
      e.cyc = is_clear ? c0 + k : c0 + k + 3;
      expq.push_back(e);
    end
    exp_start = c0;
    exp_done = is_clear ? c0 + TAPS : c0 + TAPS + 3;
    armed = 1'b1;
    start = !is_clear;
    clear = is_clear;
    mu_e = mu;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    mu_e = E_WIDTH'($urandom());
  endtask

  task automatic finish_sweep(input int c0, input bit poke, input string tag);
    bit seen;
    int nbad;
    seen = 1'b0;
    for (int i = 0; i < TAPS + 20 && !seen; i++) begin
      if (poke && (cyc == c0 + 10 || cyc == c0 + 200)) begin
        start = 1'b1;
        clear = 1'b1;
        mu_e = E_WIDTH'($urandom());
      end else begin
        start = 1'b0;
        clear = 1'b0;
      end
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    clear = 1'b0;
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_drained"}, expq.size(), 0);
    nbad = 0;
    for (int k = 0; k < TAPS; k++) if (wmem[k] !== model[k]) nbad++;
    chk({tag, "_readback_bad_taps"}, nbad, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic abort_sweep(input logic signed [E_WIDTH-1:0] mu, input int tap);
    int c0;
    int nbad;
    launch(1'b0, mu, c0);
    for (int i = 0; i < tap + 10 && cyc < c0 + tap + 4; i++) @(negedge clk);
    chk("abort_reach_cycle", cyc, c0 + tap + 4);
    #2 rst = 1'b1;
    #1;
    chk("abort_wr_en", ram.w_wr_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_w_rd_addr", ram.w_rd_addr, 0);
    chk("abort_x_rd_addr", ram.x_rd_addr, 0);
    chk("abort_w_wr_addr", ram.w_wr_addr, 0);
    chk("abort_w_wr_data", ram.w_wr_data, 0);
    expq.delete();
    armed = 1'b0;
    for (int k = tap + 1; k < TAPS; k++) model[k] = old_w[k];
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    nbad = 0;
    for (int k = 0; k < TAPS; k++) if (wmem[k] !== model[k]) nbad++;
    chk("abort_readback_bad_taps", nbad, 0);
  endtask

  initial begin
    int c0;
    for (int k = 0; k < TAPS; k++) begin
      xmem[k] = '0;
      load_w[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_w_wr_en", ram.w_wr_en, 0);
    chk("rst_w_wr_data", ram.w_wr_data, 0);
    chk("rst_w_wr_addr", ram.w_wr_addr, 0);
    chk("rst_w_rd_addr", ram.w_rd_addr, 0);
    chk("rst_x_rd_addr", ram.x_rd_addr, 0);
    rst = 1'b0;

    chk("model_pos", upd(100, 2, 16384), 101);
    chk("model_floor_neg", upd(0, 1, -1), -1);
    chk("model_floor_pos", upd(0, 1, 1), 0);
    chk("model_sat_hi", upd(WMAX, 32767, 32767), 64'sh03ff_ffff_ffff_ffff);
    chk("model_sat_lo", upd(WMIN, -32768, 32767), -64'sh0400_0000_0000_0000);

    launch(1'b1, '0, c0);
    finish_sweep(c0, 1'b0, "clear");
    chk("clear_w0", wmem[0], 0);
    chk("clear_w511", wmem[TAPS-1], 0);

    set_all(100, 16'sd2);
    launch(1'b0, 16'sd16384, c0);
    finish_sweep(c0, 1'b0, "pos");
    chk("pos_w0", wmem[0], 101);
    chk("pos_w511", wmem[TAPS-1], 101);

    set_all(0, 16'sd1);
    launch(1'b0, -16'sd1, c0);
    finish_sweep(c0, 1'b0, "floor_neg");
    chk("floor_neg_w7", wmem[7], -1);

    set_all(0, 16'sd1);
    launch(1'b0, 16'sd1, c0);
    finish_sweep(c0, 1'b0, "floor_pos");
    chk("floor_pos_w7", wmem[7], 0);

    for (int k = 0; k < TAPS; k++) begin
      load_w[k] = rnd_w();
      xmem[k] = rnd_x();
    end
    load_w[5] = W_WIDTH'(WMAX);
    xmem[5] = 16'sh7fff;
    load_w[6] = W_WIDTH'(WMIN);
    xmem[6] = 16'sh8000;
    do_load();
    launch(1'b0, 16'sd32767, c0);
    finish_sweep(c0, 1'b0, "sat");
    chk("sat_w5", wmem[5], 64'sh03ff_ffff_ffff_ffff);
    chk("sat_w6", wmem[6], -64'sh0400_0000_0000_0000);

    rand_fill();
    launch(1'b0, E_WIDTH'($urandom()), c0);
    finish_sweep(c0, 1'b1, "busy_prot");

    rand_fill();
    abort_sweep(E_WIDTH'($urandom()), 100);

    for (int r = 0; r < 4; r++) begin
      rand_fill();
      launch(1'b0, E_WIDTH'($urandom()), c0);
      finish_sweep(c0, 1'b0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lms_weight_update.md
# lms_weight_update

Coefficient-update engine for the adaptive LMS echo/noise canceller. On each adaptation request it sweeps every tap: it reads weight w[k] from the weight RAM (w_lms_ram, 9-bit address, 59-bit data, 1-cycle unregistered read) and sample x[n-k] from the sample-history RAM. It computes w[k] + ((mu_e·x) >>> SHIFT) with saturation and writes the result back to the same weight RAM, at one tap per cycle. The block also provides a clear sweep that zeroes all weights.

## Interface
- TAPS, 512, number of taps swept; 4..2^ADDR_W.
- ADDR_W, 9, weight/history address width.
- W_WIDTH, 59, signed weight width.
- X_WIDTH, 16, signed sample width.
- E_WIDTH, 16, signed step-scaled error (mu·e) width.
- SHIFT, 15, arithmetic right shift applied to the product.

Ports:
- clk  in  1  single clock for all logic; the weight RAM's wr_clk/rd_clk are tied to it.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  one-cycle update request; sampled only in IDLE.
- clear  in  1  one-cycle request to zero all weights; sampled only in IDLE; wins over start.
- mu_e  in  E_WIDTH  signed step-scaled error; latched when start is accepted.
- x_rd_addr  out  ADDR_W  history RAM read address (registered).
- x_rd_data  in  X_WIDTH  history RAM data, valid 1 cycle after the address.
- w_rd_addr  out  ADDR_W  weight RAM read address (registered).
- w_rd_data  in  W_WIDTH  weight RAM data, valid 1 cycle after the address.
- w_wr_addr  out  ADDR_W  weight RAM write address.
- w_wr_data  out  W_WIDTH  weight RAM write data.
- w_wr_en  out  1  weight RAM write enable.
- busy  out  1  high from acceptance until done.
- done  out  1  one-cycle pulse when a sweep completes.

## Operation
- FSM states:
  - IDLE: clear → CLEAR; else start → UPDATE.
  - CLEAR: after the tap TAPS-1 write → IDLE, pulse done.
  - UPDATE: after the tap TAPS-1 write drains → IDLE, pulse done.
  - start/clear outside IDLE are ignored, not queued.
- CLEAR: w_wr_addr counts 0..TAPS-1, one per cycle, with w_wr_data=0 and w_wr_en=1. No reads are issued.
- UPDATE datapath, 3-stage pipeline per tap k:
  - S0: w_rd_addr = x_rd_addr = k, with k incrementing 0..TAPS-1.
  - S1: the RAMs present w[k] and x[n-k].
  - S2: register p = mu_e_latched · x (E_WIDTH+X_WIDTH = 32-bit signed) and the w[k] copy.
  - S3: s = w + sign_extend(p >>> SHIFT) at W_WIDTH+1 bits; saturate to [-2^(W_WIDTH-1), 2^(W_WIDTH-1)-1]; drive w_wr_data=s, w_wr_addr=k, w_wr_en=1.
- Shift is arithmetic, so it rounds toward −∞ (floor).
- Read/write address conflict cannot occur: the write address trails the read address by 3 and TAPS≥4. The block needs no bypass.
- mu_e is held constant for the whole sweep, even if the input changes.
- Reset values: state IDLE, all addresses 0, w_wr_data 0, w_wr_en 0, busy 0, done 0, mu_e latch 0.
- rst mid-sweep aborts immediately, and no further writes occur. Taps already written keep their new values; the remaining taps are unchanged. No done pulse is produced.

## Timing
- Let E0 be the edge that accepts start. From E0: busy=1, w_rd_addr=x_rd_addr=0.
- Read address for tap k is driven after edge E0+k.
- Write for tap k: w_wr_en=1 during the cycle after edge E0+k+3.
- Address-to-write latency is 3 cycles; throughput is 1 tap/cycle. w_wr_en stays high for TAPS consecutive cycles.
- done=1 and busy=0 in the cycle after edge E0+TAPS+3. An UPDATE sweep takes TAPS+4 cycles from start to IDLE.
- CLEAR accepted at E0: write tap k in the cycle after E0+k. done in the cycle after E0+TAPS.
- A new start is accepted in the cycle in which done is high.
- Back-to-back sweeps therefore space at TAPS+4 cycles.

## Test plan
- Clear sweep: rst, then clear. Expect TAPS writes of 0 to addresses 0..511, then done exactly 513 cycles after acceptance. A subsequent readback of any address returns 0.
- Positive update: weights = 100, x = 2 on all taps, mu_e = 16384. Expect every write = 101. The first w_wr_en occurs 3 cycles after address 0 is issued, and done follows 516 cycles after start.
- Floor rounding: weights = 0, x = 1, mu_e = −1 → every written weight = −1. With mu_e = +1 the product 1>>>15 = 0, so every written weight = 0.
- Saturation: tap 5 = 2^58−1, x = 32767, mu_e = 32767 → write 2^58−1. Tap 6 = −2^58, x = −32768, mu_e = 32767 → write −2^58.
- Busy protection: pulse start and clear at cycles 10 and 200 of a running sweep. Expect no restart, a single done, and write results computed with the originally latched mu_e even though mu_e changes mid-sweep.
- Mid-sweep reset: assert rst after the tap 100 write. Expect outputs to return to their reset values asynchronously, taps 0..100 updated and 101..511 unchanged, no done pulse, and a fresh start behaving normally.
